// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg : shared encodings and constants for the HI/LO divide controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package md_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_DIV  = 3'd1,
    OP_MTHI = 3'd2,
    OP_MTLO = 3'd3,
    OP_MFHI = 3'd4,
    OP_MFLO = 3'd5
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DRAIN  = 3'd4
  } md_state_e;

  localparam logic [31:0] HILO_RST     = 32'h0000_0000;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV0_LO      = 32'hFFFF_FFFF;

  // Codes 6 and 7 behave as NONE and therefore never stall.
  function automatic logic is_hilo_op(input logic [2:0] code);
    return (code >= OP_DIV) && (code <= OP_MFLO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_regs.sv
// ---------------------------------------------------------------------------
// hilo_regs : architectural HI/LO registers with independent write enables
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hilo_regs
  import md_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        hi_we_i,
  input  logic [31:0] hi_wdata_i,
  input  logic        lo_we_i,
  input  logic [31:0] lo_wdata_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_q;
  logic [31:0] lo_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q <= HILO_RST;
      lo_q <= HILO_RST;
    end else begin
      if (hi_we_i) hi_q <= hi_wdata_i;
      if (lo_we_i) lo_q <= lo_wdata_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_div_ctrl : sequences DIV / HI-LO moves around a 32-cycle divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hilo_div_ctrl
  import md_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        err,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  md_state_e         state_q, state_d;
  logic              discard_q, discard_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [31:0]       dividend_q, dividend_d;
  logic [31:0]       divisor_q, divisor_d;

  logic              hi_we, lo_we;
  logic [31:0]       hi_wdata, lo_wdata;
  logic              div_by_zero, div_ovf;

  assign div_by_zero = (rt_val == 32'h0);
  assign div_ovf     = (rs_val == OVF_DIVIDEND) && (rt_val == OVF_DIVISOR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      discard_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      run_cnt_q  <= '0;
      dividend_q <= 32'h0;
      divisor_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      done_q     <= done_d;
      err_q      <= err_d;
      run_cnt_q  <= run_cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    done_d     = 1'b0;
    err_d      = err_q;
    run_cnt_d  = run_cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_wdata   = div_r;
    lo_wdata   = div_q;

    unique case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        run_cnt_d = '0;
        if (op_valid) begin
          unique case (op)
            OP_DIV: begin
              // Short paths finish here without ever starting the divider.
              if (div_by_zero) begin
                hi_we    = 1'b1;
                hi_wdata = rs_val;
                lo_we    = 1'b1;
                lo_wdata = DIV0_LO;
                done_d   = 1'b1;
              end else if (div_ovf) begin
                hi_we    = 1'b1;
                hi_wdata = HILO_RST;
                lo_we    = 1'b1;
                lo_wdata = OVF_DIVIDEND;
                done_d   = 1'b1;
              end else begin
                dividend_d = rs_val;
                divisor_d  = rt_val;
                state_d    = ST_START;
              end
            end
            OP_MTHI: begin
              hi_we    = 1'b1;
              hi_wdata = rs_val;
            end
            OP_MTLO: begin
              lo_we    = 1'b1;
              lo_wdata = rs_val;
            end
            default: ;
          endcase
        end
      end

      ST_START: begin
        if (flush) discard_d = 1'b1;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (flush) discard_d = 1'b1;
        if (!div_busy) begin
          state_d = (discard_q || flush) ? ST_DRAIN : ST_SETTLE;
        end else if (run_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // The divider never finished; abandon the result and flag it.
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
      end

      ST_SETTLE: begin
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        state_d = ST_IDLE;
      end

      ST_DRAIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  hilo_regs u_hilo_regs (
    .clock      (clock),
    .reset      (reset),
    .hi_we_i    (hi_we),
    .hi_wdata_i (hi_wdata),
    .lo_we_i    (lo_we),
    .lo_wdata_i (lo_wdata),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  assign stall        = op_valid && is_hilo_op(op) && (state_q != ST_IDLE);
  assign done         = done_q || (state_q == ST_SETTLE);
  assign err          = err_q;
  assign div_start    = (state_q == ST_START);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_div_ctrl : self-checking bench with a behavioural 32-cycle divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hilo_div_ctrl;
  import md_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        flush;
  logic        stall, done, err, div_start;
  logic [31:0] hi, lo, div_dividend, div_divisor;
  logic        div_busy;
  logic [31:0] div_q, div_r;

  logic        m_busy;
  int          m_cnt;
  logic        busy_stuck = 1'b0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          done_cyc;
    int          starts;
  } vec_t;

  vec_t vecs[12];

  hilo_div_ctrl #(.TIMEOUT(40)) dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op           (op),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .flush        (flush),
    .stall        (stall),
    .hi           (hi),
    .lo           (lo),
    .done         (done),
    .err          (err),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (div_busy),
    .div_q        (div_q),
    .div_r        (div_r)
  );

  always #5 clock = ~clock;

  // Divider: samples start, busy for 32 cycles, then presents quotient/remainder.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      div_q  <= 32'h0;
      div_r  <= 32'h0;
    end else if (div_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 32;
      if (div_divisor != 32'h0) begin
        div_q <= $signed(div_dividend) / $signed(div_divisor);
        div_r <= $signed(div_dividend) % $signed(div_divisor);
      end
    end else if (m_cnt > 0) begin
      m_cnt  <= m_cnt - 1;
      m_busy <= (m_cnt > 1);
    end
  end

  assign div_busy = m_busy | busy_stuck;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One op at cycle 0, optional flush in cycle fl, then 37 more cycles observed.
  task automatic exec_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int fl, output int dc, output int st);
    dc = -1;
    st = 0;
    @(negedge clock);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b; flush = (fl == 0);
    @(posedge clock); #1;
    op_valid = 1'b0; op = OP_NONE; flush = 1'b0;
    for (int c = 1; c <= 37; c++) begin
      flush = (fl == c);
      @(negedge clock);
      if (done) dc = (dc == -1) ? c : -2;
      if (div_start) st++;
      @(posedge clock); #1;
    end
    flush = 1'b0;
  endtask

  // A DIV at cycle 0, then a second op presented from cycle p until accepted.
  task automatic seq2(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o2,
                      input logic [31:0] a2, input logic [31:0] b2, input int p, input int fl,
                      input int ncyc, output int acc_c, output int stall_n, output int d1,
                      output int d2, output int s1, output int s2, output int err_c,
                      output logic [31:0] lo_acc);
    acc_c = -1; stall_n = 0; d1 = -1; d2 = -1; s1 = -1; s2 = -1; err_c = -1; lo_acc = '0;
    @(negedge clock);
    op_valid = 1'b1; op = OP_DIV; rs_val = a; rt_val = b;
    @(posedge clock); #1;
    op_valid = 1'b0; op = OP_NONE;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == p) begin
        op_valid = 1'b1; op = o2; rs_val = a2; rt_val = b2;
      end
      flush = (c == fl);
      @(negedge clock);
      if (op_valid) begin
        if (stall) stall_n++;
        else if (acc_c < 0) begin
          acc_c  = c;
          lo_acc = lo;
        end
      end
      if (done) begin
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
      if (div_start) begin
        if (s1 < 0) s1 = c; else if (s2 < 0) s2 = c;
      end
      if (err && err_c < 0) err_c = c;
      @(posedge clock); #1;
      if (acc_c > 0) op_valid = 1'b0;
    end
    flush = 1'b0;
    op_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc, st, acc, sn, d1, d2, s1, s2, ec, fl, edc, est;
    logic [31:0] lacc, hold_lo, hold_hi, ra, rb, mhi, mlo;
    logic [2:0] ro;
    int k;

    vecs[0]  = '{OP_DIV,  32'd7,          32'd2,          32'd1,          32'd3,          35,  1};
    vecs[1]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  35,  1};
    vecs[2]  = '{OP_DIV,  32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1,   0};
    vecs[3]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1,   0};
    vecs[4]  = '{OP_MTHI, 32'h1234,       32'd0,          32'h1234,       32'h8000_0000,  -1,  0};
    vecs[5]  = '{OP_MTLO, 32'hABCD,       32'd0,          32'h1234,       32'hABCD,       -1,  0};
    vecs[6]  = '{OP_MFHI, 32'h5555,       32'd0,          32'h1234,       32'hABCD,       -1,  0};
    vecs[7]  = '{OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2,  35,  1};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'd2,          32'h0,          32'hC000_0000,  35,  1};
    vecs[9]  = '{OP_DIV,  32'd0,          32'd5,          32'h0,          32'h0,          35,  1};
    vecs[10] = '{OP_DIV,  32'h8000_0001,  32'hFFFF_FFFF,  32'h0,          32'h7FFF_FFFF,  35,  1};
    vecs[11] = '{OP_DIV,  32'h8000_0000,  32'd0,          32'h8000_0000,  32'hFFFF_FFFF,  1,   0};

    reset = 1'b1; op_valid = 1'b1; op = OP_DIV; rs_val = 32'd7; rt_val = 32'd2; flush = 1'b0;
    repeat (3) @(negedge clock);
    check32("reset_hi", hi, 32'h0);
    check32("reset_lo", lo, 32'h0);
    check32("reset_ctl", {28'h0, stall, done, err, div_start}, 32'h0);
    check32("reset_ops", div_dividend | div_divisor, 32'h0);
    op_valid = 1'b0; op = OP_NONE;
    reset = 1'b0;

    foreach (vecs[i]) begin
      exec_op(vecs[i].op, vecs[i].rs, vecs[i].rt, -1, dc, st);
      check32($sformatf("vec%0d_done_cycle", i), 32'(dc), 32'(vecs[i].done_cyc));
      check32($sformatf("vec%0d_starts", i), 32'(st), 32'(vecs[i].starts));
      check32($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check32($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // Dependent MFLO behind a running divide.
    seq2(32'hFFFF_FFF9, 32'd2, OP_MFLO, 32'h0, 32'h0, 5, -1, 40, acc, sn, d1, d2, s1, s2, ec, lacc);
    check32("mflo_accept_cycle", 32'(acc), 32'd36);
    check32("mflo_stall_cycles", 32'(sn), 32'd31);
    check32("mflo_lo", lacc, 32'hFFFF_FFFD);
    check32("mflo_div_done", 32'(d1), 32'd35);
    check32("mflo_hi", hi, 32'hFFFF_FFFF);

    // Back-to-back DIV.
    seq2(32'd7, 32'd2, OP_DIV, 32'd9, 32'd3, 1, -1, 75, acc, sn, d1, d2, s1, s2, ec, lacc);
    check32("b2b_accept_cycle", 32'(acc), 32'd36);
    check32("b2b_stall_cycles", 32'(sn), 32'd35);
    check32("b2b_start1", 32'(s1), 32'd1);
    check32("b2b_start2", 32'(s2), 32'd37);
    check32("b2b_done1", 32'(d1), 32'd35);
    check32("b2b_done2", 32'(d2), 32'd71);
    check32("b2b_hi", hi, 32'h0);
    check32("b2b_lo", lo, 32'd3);

    // Flushed divide is drained and discarded.
    exec_op(OP_MTHI, 32'h1234, 32'h0, -1, dc, st);
    hold_lo = lo;
    seq2(32'd9, 32'd3, OP_MFHI, 32'h0, 32'h0, 2, 10, 40, acc, sn, d1, d2, s1, s2, ec, lacc);
    check32("flush_done", 32'(d1), 32'hFFFF_FFFF);
    check32("flush_start", 32'(s1), 32'd1);
    check32("flush_accept_cycle", 32'(acc), 32'd36);
    check32("flush_hi", hi, 32'h1234);
    check32("flush_lo", lo, hold_lo);

    // Asynchronous reset in the middle of a divide.
    exec_op(OP_MTHI, 32'h55, 32'h0, -1, dc, st);
    @(negedge clock);
    op_valid = 1'b1; op = OP_DIV; rs_val = 32'd7; rt_val = 32'd2;
    @(posedge clock); #1;
    op_valid = 1'b0; op = OP_NONE;
    repeat (19) @(posedge clock);
    #2;
    op_valid = 1'b1; op = OP_MFHI;
    #1;
    check32("midrun_stall", {31'h0, stall}, 32'd1);
    check32("midrun_dividend", div_dividend, 32'd7);
    reset = 1'b1;
    #1;
    check32("rst_mid_hi", hi, 32'h0);
    check32("rst_mid_lo", lo, 32'h0);
    check32("rst_mid_ctl", {28'h0, stall, done, err, div_start}, 32'h0);
    check32("rst_mid_ops", div_dividend | div_divisor, 32'h0);
    @(negedge clock);
    reset = 1'b0; op_valid = 1'b0; op = OP_NONE;
    exec_op(OP_DIV, 32'd8, 32'd4, -1, dc, st);
    check32("post_rst_done", 32'(dc), 32'd35);
    check32("post_rst_hi", hi, 32'h0);
    check32("post_rst_lo", lo, 32'd2);

    // Divider that never finishes.
    hold_hi = hi;
    busy_stuck = 1'b1;
    seq2(32'd7, 32'd2, OP_MFHI, 32'h0, 32'h0, 2, -1, 60, acc, sn, d1, d2, s1, s2, ec, lacc);
    busy_stuck = 1'b0;
    check32("tmo_err_window", {31'h0, (ec == 42) || (ec == 43)}, 32'd1);
    check32("tmo_accept_after_drain", 32'(acc), 32'(ec + 1));
    check32("tmo_no_done", 32'(d1), 32'hFFFF_FFFF);
    check32("tmo_hi", hi, hold_hi);
    exec_op(OP_MTLO, 32'h77, 32'h0, -1, dc, st);
    check32("err_sticky", {31'h0, err}, 32'd1);
    check32("mtlo_after_err", lo, 32'h77);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check32("err_cleared", {31'h0, err}, 32'd0);

    // Randomised operations against an architectural model of HI/LO.
    mhi = 32'h0;
    mlo = 32'h0;
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(7, 0));
      if ($urandom_range(1, 0) == 1) ro = OP_DIV;
      ra = $urandom;
      rb = $urandom;
      k = $urandom_range(7, 0);
      if (k == 0) rb = 32'h0;
      else if (k == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (k == 2) rb = 32'($urandom_range(9, 1));
      fl = -1;
      if ($urandom_range(3, 0) == 0) begin
        fl = $urandom_range(36, 0);
        if (fl == 34) fl = 33;
      end
      edc = -1;
      est = 0;
      if (ro == OP_DIV) begin
        if (rb == 32'h0) begin
          mhi = ra; mlo = 32'hFFFF_FFFF; edc = 1;
        end else if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) begin
          mhi = 32'h0; mlo = 32'h8000_0000; edc = 1;
        end else begin
          est = 1;
          if (!(fl >= 1 && fl <= 33)) begin
            mlo = $signed(ra) / $signed(rb);
            mhi = $signed(ra) % $signed(rb);
            edc = 35;
          end
        end
      end else if (ro == OP_MTHI) mhi = ra;
      else if (ro == OP_MTLO) mlo = ra;
      exec_op(ro, ra, rb, fl, dc, st);
      check32($sformatf("rnd%0d_op%0d_done", i, ro), 32'(dc), 32'(edc));
      check32($sformatf("rnd%0d_op%0d_starts", i, ro), 32'(st), 32'(est));
      check32($sformatf("rnd%0d_op%0d_hi", i, ro), hi, mhi);
      check32($sformatf("rnd%0d_op%0d_lo", i, ro), lo, mlo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Sequencer between the CPU execute stage and the 32-cycle signed restoring divider: accepts DIV and HI/LO move operations, launches the divider, stalls dependent instructions while it runs, and owns the HI/LO architectural registers. Divide-by-zero and the 0x8000_0000 / −1 overflow case are resolved locally without starting the divider. Flushed divides are drained and discarded.

## Interface
- TIMEOUT, 40: maximum cycles in RUN before `err` is raised.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clock.
- op_valid  in  1  execute stage presents an operation this cycle.
- op  in  3  0 NONE, 1 DIV, 2 MTHI, 3 MTLO, 4 MFHI, 5 MFLO; other codes are treated as NONE.
- rs_val  in  32  DIV dividend / MTHI/MTLO data.
- rt_val  in  32  DIV divisor.
- flush  in  1  cancel the in-flight DIV result.
- stall  out  1  hold the execute stage; combinational.
- hi, lo  out  32 each  architectural HI/LO, registered.
- done  out  1  one-cycle pulse in the cycle HI/LO are written by a DIV.
- err  out  1  sticky divider timeout.
- div_start  out  1  divider start, exactly one cycle high.
- div_dividend, div_divisor  out  32 each  registered operands, stable from START until the controller returns to IDLE.
- div_busy  in  1  divider busy.
- div_q, div_r  in  32 each  divider quotient and remainder.

## Operation
- States: IDLE, START, RUN, SETTLE, DRAIN.
- IDLE with `op_valid`:
  - DIV, divisor == 0: HI <= rs_val, LO <= 32'hFFFF_FFFF, `done` pulses at the next edge, stay in IDLE.
  - DIV, rs_val == 32'h8000_0000 and rt_val == 32'hFFFF_FFFF: HI <= 0, LO <= 32'h8000_0000, `done` pulses, stay in IDLE.
  - DIV, other operands: latch operands, go to START.
  - MTHI/MTLO: write HI/LO at the edge.
  - MFHI/MFLO: no action; the consumer reads `hi`/`lo` directly.
- START: `div_start` = 1; go to RUN.
- RUN: wait while `div_busy` = 1. When `div_busy` = 0, go to SETTLE, or to DRAIN if a flush has been recorded.
- SETTLE: capture HI <= div_r and LO <= div_q at the edge. `done` = 1 during this cycle. Go to IDLE.
- DRAIN: one cycle with no HI/LO write and no `done`; go to IDLE.
- `flush` in START or RUN sets an internal `discard` flag, cleared on return to IDLE.
  - The divider cannot be aborted, so the controller waits for `div_busy` to drop.
  - `flush` in IDLE or SETTLE has no effect.
- stall = op_valid && op ∈ {DIV, MTHI, MTLO, MFHI, MFLO} && state != IDLE. NONE never stalls.
- `err`:
  - Set if RUN lasts more than TIMEOUT cycles; the controller then forces state to DRAIN.
  - Cleared only by reset.
- Reset values: state IDLE; hi, lo, div_dividend, div_divisor = 0; stall, done, err, div_start, discard = 0.
- Reset mid-operation returns to IDLE immediately. The divider shares `reset`, so no drain is needed.

## Timing
- A DIV accepted at edge 0 gives:
  - START in cycle 1, with the divider sampling at edge 1.
  - `div_busy` high in cycles 2–33.
  - RUN sees busy low in cycle 34.
  - SETTLE in cycle 35, with `done` = 1.
  - New HI/LO visible from cycle 36.
- `stall` is asserted for any HI/LO-class op presented in cycles 1–35.
- The divide-by-zero and overflow short paths complete at edge 0; results are visible in cycle 1.
- MTHI/MTLO latency is one edge.
- Back-to-back DIV: the second DIV is stalled until cycle 36 and accepted at edge 36.
- A flush and a new op in the same IDLE cycle: the op executes normally.

## Structure
- Package `md_pkg`: `op` encodings, the state enum, the HI/LO reset constant, and the overflow operand constants (32'h8000_0000, 32'hFFFF_FFFF).
- No sub-module is required. HI/LO storage may be factored as `hilo_regs` (two 32-bit registers with independent write enables).

## Test plan
- DIV 7 / 2 → `done` in cycle 35; HI = 1, LO = 3 from cycle 36.
- DIV −7 (0xFFFF_FFF9) / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. Follow with MFLO in cycle 5 → `stall` high cycles 5–35; MFLO proceeds in cycle 36 with LO = 0xFFFF_FFFD.
- DIV 5 / 0 → no `div_start`; HI = 5, LO = 0xFFFF_FFFF in cycle 1. DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0.
- MTHI 0x1234 then DIV 9 / 3 with `flush` in cycle 10 → no `done`; DRAIN in cycle 35; HI stays 0x1234.
- `reset` pulse in cycle 20 of a DIV → all outputs 0 immediately; a new DIV 8 / 4 then completes with LO = 2, HI = 0.
- Model with `div_busy` stuck high → `err` set after TIMEOUT (40) cycles in RUN; controller returns to IDLE via DRAIN; `stall` drops.
